// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared RISC-V fetch-path types and constants.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 - returned in place of real data on an error response
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One fetch response as it travels the pipeline and the response FIFO
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] instr;
    logic            err;
  } fetch_rsp_t;

endpackage
`default_nettype wire

// File: rtl/imem_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : imem_rsp_fifo
// Description : Synchronous first-word-fall-through FIFO of fetch responses
//               with flush and an occupancy count output.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_rsp_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_rsp_t                 push_data_i,
  input  logic                       pop_i,
  output fetch_rsp_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  fetch_rsp_t    storage_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          w_do_push;
  logic          w_do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Next-state for pointers and count; flush empties the FIFO outright
  always_comb begin
    w_do_pop  = pop_i && (count_q != '0);
    w_do_push = push_i && ((count_q != CW'(DEPTH)) || w_do_pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (w_do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (w_do_push && !w_do_pop)      count_d = count_q + CW'(1);
      else if (!w_do_push && w_do_pop) count_d = count_q - CW'(1);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset
  always_ff @(posedge clk) begin
    if (w_do_push && !flush_i) storage_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = storage_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_responder
// Description : Instruction-memory end of the fetch request/response link.
//               Fixed-latency reads, backpressure via an outstanding-request
//               budget, flush of in-flight fetches, program-load write port.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_responder
  import rv_pkg::*;
#(
  parameter int              IMEM_DEPTH = 256,
  parameter int              LATENCY    = 2,
  parameter logic [XLEN-1:0] ERR_INSTR  = NOP_INSTR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [XLEN-1:0]               req_addr,
  input  logic                          flush,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [XLEN-1:0]               rsp_addr,
  output logic [XLEN-1:0]               rsp_instr,
  output logic                          rsp_err,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [XLEN-1:0]               load_data
);

  localparam int AW        = $clog2(IMEM_DEPTH);
  localparam int RSP_DEPTH = LATENCY + 1;
  localparam int CW        = $clog2(RSP_DEPTH + 1);

  logic [XLEN-1:0] mem_q [IMEM_DEPTH];
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [LATENCY-1:0] pipe_vld_q;
  fetch_rsp_t      pipe_q [LATENCY];

  logic            w_accept;
  logic            w_consume;
  logic            w_req_err;
  fetch_rsp_t      w_req_rsp;
  fetch_rsp_t      w_head;
  logic [CW-1:0]   w_fifo_count;

  // Outstanding budget equals FIFO depth, so the FIFO can never overflow
  assign req_ready = !rst && !flush && (outstanding_q < CW'(RSP_DEPTH));
  assign w_accept  = req_valid && req_ready;
  assign w_consume = rsp_valid && rsp_ready && !flush;

  // Misaligned or beyond-the-array addresses never touch the memory
  assign w_req_err       = (req_addr[1:0] != 2'b00) || (req_addr[XLEN-1:AW+2] != '0);
  assign w_req_rsp.addr  = req_addr;
  assign w_req_rsp.err   = w_req_err;
  assign w_req_rsp.instr = w_req_err ? ERR_INSTR : mem_q[req_addr[AW+1:2]];

  // Program-load port; read above sees the pre-write word (read-before-write)
  always_ff @(posedge clk) begin
    if (load_en) mem_q[load_addr] <= load_data;
  end

  // Outstanding counter next-state: +accept, -consume, cleared by flush
  always_comb begin
    outstanding_d = outstanding_q;
    if (flush)                         outstanding_d = '0;
    else if (w_accept && !w_consume)   outstanding_d = outstanding_q + CW'(1);
    else if (!w_accept && w_consume)   outstanding_d = outstanding_q - CW'(1);
  end

  // Outstanding counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) outstanding_q <= '0;
    else     outstanding_q <= outstanding_d;
  end

  // LATENCY-stage valid-qualified delay line; it never stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else if (flush) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= w_accept;
      pipe_q[0]     <= w_req_rsp;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_q[i]     <= pipe_q[i-1];
      end
    end
  end

  imem_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .push_i      (pipe_vld_q[LATENCY-1]),
    .push_data_i (pipe_q[LATENCY-1]),
    .pop_i       (w_consume),
    .head_o      (w_head),
    .count_o     (w_fifo_count)
  );

  // Response fields read as zero whenever nothing is presented
  assign rsp_valid = (w_fifo_count != '0);
  assign rsp_addr  = rsp_valid ? w_head.addr  : '0;
  assign rsp_instr = rsp_valid ? w_head.instr : '0;
  assign rsp_err   = rsp_valid ? w_head.err   : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_responder
// Description : Self-checking bench for imem_responder against a queue-based
//               transaction model of the fetch link.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_responder;

  localparam int L     = 2;
  localparam int DEPTH = 256;
  localparam int RSPD  = L + 1;

  logic        clk, rst, req_valid, req_ready, flush, rsp_valid, rsp_ready, rsp_err, load_en;
  logic [31:0] req_addr, rsp_addr, rsp_instr, load_data;
  logic [7:0]  load_addr;

  // Expected response plus the edge index at which it was accepted
  typedef struct {
    logic [31:0] a;
    logic [31:0] i;
    logic        e;
    int          t;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] got_a[$];
  logic [31:0] got_i[$];
  logic        got_e[$];
  int          cyc = 0;
  int          tests = 0;
  int          failed = 0;

  imem_responder #(
    .IMEM_DEPTH (DEPTH),
    .LATENCY    (L),
    .ERR_INSTR  (32'h0000_0013)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_addr  (rsp_addr),
    .rsp_instr (rsp_instr),
    .rsp_err   (rsp_err),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Head of the model is presented once LATENCY edges have passed since its accept
  function automatic bit m_valid();
    return (q.size() > 0) && (q[0].t + L <= cyc);
  endfunction

  function automatic bit exp_ready();
    return !rst && !flush && (q.size() < RSPD);
  endfunction

  function automatic exp_t m_head();
    exp_t h;
    h = '{a: 32'h0, i: 32'h0, e: 1'b0, t: 0};
    if (q.size() > 0) h = q[0];
    return h;
  endfunction

  function automatic exp_t make_rsp(input logic [31:0] a, input int t);
    exp_t r;
    r.a = a;
    r.t = t;
    r.e = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    r.i = r.e ? 32'h0000_0013 : mem_m[a[9:2]];
    return r;
  endfunction

  // Advance one clock edge and apply the transaction rules to the model
  task automatic tick();
    bit acc, con;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      acc = req_valid && !flush && (q.size() < RSPD);
      con = !flush && rsp_ready && m_valid();
      if (flush) q.delete();
      else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(make_rsp(req_addr, cyc + 1));
      end
    end
    if (load_en) mem_m[load_addr] = load_data;
    cyc++;
    #1;
  endtask

  task automatic clear_got();
    got_a.delete();
    got_i.delete();
    got_e.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'h0;
    tick();
    tick();
    tests++;
    if (rsp_valid !== 1'b0 || rsp_addr !== 32'h0 || rsp_instr !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: got v=%b a=%h i=%h e=%b rdy=%b, expected all zero", rsp_valid, rsp_addr, rsp_instr, rsp_err, req_ready);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_release_ready: got %b, expected 1", req_ready);
    end
  endtask

  task automatic test_load();
    for (int i = 0; i < DEPTH; i++) begin
      load_en = 1'b1;
      load_addr = 8'(i);
      load_data = (i < 4) ? 32'(32'h1111_1111 * (i + 1)) : $urandom;
      tick();
    end
    load_en = 1'b0;
  endtask

  task automatic test_stream();
    exp_t h;
    int first_v, last_v, nv, acc_edge;
    first_v = -1; last_v = -1; nv = 0; acc_edge = -1;
    clear_got();
    rsp_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      req_valid = (c < 3);
      req_addr = 32'(c * 4);
      #1; h = m_head(); tests++;
      if (req_ready !== exp_ready() || rsp_valid !== m_valid() ||
          (m_valid() && (rsp_addr !== h.a || rsp_instr !== h.i || rsp_err !== h.e))) begin
        failed++;
        $display("FAIL stream_cycle %0d: got rdy=%b v=%b a=%h i=%h e=%b, expected rdy=%b v=%b a=%h i=%h e=%b",
                 cyc, req_ready, rsp_valid, rsp_addr, rsp_instr, rsp_err, exp_ready(), m_valid(), h.a, h.i, h.e);
      end
      if (c == 0 && req_ready) acc_edge = cyc + 1;
      if (rsp_valid) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        nv++;
      end
      if (rsp_valid && rsp_ready && !flush) begin got_a.push_back(rsp_addr); got_i.push_back(rsp_instr); got_e.push_back(rsp_err); end
      tick();
    end
    req_valid = 1'b0;
    tests++;
    if (first_v - acc_edge != L || nv != 3 || last_v - first_v != 2) begin
      failed++;
      $display("FAIL stream_timing: got first=%0d accept=%0d valid_cycles=%0d last=%0d, expected first-accept=%0d, 3 consecutive",
               first_v, acc_edge, nv, last_v, L);
    end
    tests++;
    if (got_i.size() != 3 || got_i[0] !== 32'h1111_1111 || got_i[1] !== 32'h2222_2222 ||
        got_i[2] !== 32'h3333_3333 || got_e[0] || got_e[1] || got_e[2]) begin
      failed++;
      $display("FAIL stream_data: got %0d responses, first %h, expected 11111111 22222222 33333333 err=0",
               got_i.size(), (got_i.size() > 0) ? got_i[0] : 32'h0);
    end
  endtask

  task automatic test_backpressure();
    exp_t h;
    logic [31:0] sent[$];
    int acc;
    acc = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1;
      req_addr = 32'($urandom_range(0, 255)) << 2;
      #1; h = m_head(); tests++;
      if (req_ready !== exp_ready() || rsp_valid !== m_valid() ||
          (m_valid() && (rsp_addr !== h.a || rsp_instr !== h.i || rsp_err !== h.e))) begin
        failed++;
        $display("FAIL backpressure_cycle %0d: got rdy=%b v=%b a=%h i=%h e=%b, expected rdy=%b v=%b a=%h i=%h e=%b",
                 cyc, req_ready, rsp_valid, rsp_addr, rsp_instr, rsp_err, exp_ready(), m_valid(), h.a, h.i, h.e);
      end
      if (req_valid && req_ready) begin acc++; sent.push_back(req_addr); end
      tick();
    end
    tests++;
    if (acc != 3 || req_ready !== 1'b0) begin
      failed++;
      $display("FAIL backpressure_accepts: got %0d accepts rdy=%b, expected 3 accepts rdy=0", acc, req_ready);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    clear_got();
    for (int c = 0; c < 6; c++) begin
      #1; h = m_head(); tests++;
      if (req_ready !== exp_ready() || rsp_valid !== m_valid() ||
          (m_valid() && (rsp_addr !== h.a || rsp_instr !== h.i || rsp_err !== h.e))) begin
        failed++;
        $display("FAIL backpressure_drain %0d: got rdy=%b v=%b a=%h i=%h e=%b, expected rdy=%b v=%b a=%h i=%h e=%b",
                 cyc, req_ready, rsp_valid, rsp_addr, rsp_instr, rsp_err, exp_ready(), m_valid(), h.a, h.i, h.e);
      end
      if (rsp_valid && rsp_ready && !flush) begin got_a.push_back(rsp_addr); got_i.push_back(rsp_instr); got_e.push_back(rsp_err); end
      tick();
    end
    tests++;
    if (got_a.size() != 3 || sent.size() != 3 || got_a[0] !== sent[0] || got_a[1] !== sent[1] || got_a[2] !== sent[2]) begin
      failed++;
      $display("FAIL backpressure_order: got %0d responses, expected 3 in request order", got_a.size());
    end
  endtask

  task automatic test_flush();
    exp_t h;
    clear_got();
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 2) || (c == 3);
      req_addr = (c == 3) ? 32'h40 : 32'(8 + 4 * c);
      flush = (c == 2);
      #1; h = m_head(); tests++;
      if (req_ready !== exp_ready() || rsp_valid !== m_valid() ||
          (m_valid() && (rsp_addr !== h.a || rsp_instr !== h.i || rsp_err !== h.e))) begin
        failed++;
        $display("FAIL flush_cycle %0d: got rdy=%b v=%b a=%h i=%h e=%b, expected rdy=%b v=%b a=%h i=%h e=%b",
                 cyc, req_ready, rsp_valid, rsp_addr, rsp_instr, rsp_err, exp_ready(), m_valid(), h.a, h.i, h.e);
      end
      if (rsp_valid && rsp_ready && !flush) begin got_a.push_back(rsp_addr); got_i.push_back(rsp_instr); got_e.push_back(rsp_err); end
      tick();
    end
    flush = 1'b0;
    req_valid = 1'b0;
    tests++;
    if (got_a.size() != 1 || got_a[0] !== 32'h40) begin
      failed++;
      $display("FAIL flush_result: got %0d responses first addr %h, expected exactly one at 00000040",
               got_a.size(), (got_a.size() > 0) ? got_a[0] : 32'h0);
    end
  endtask

  task automatic test_errors();
    exp_t h;
    clear_got();
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      req_valid = (c < 2);
      req_addr = (c == 0) ? 32'h6 : 32'h400;
      #1; h = m_head(); tests++;
      if (req_ready !== exp_ready() || rsp_valid !== m_valid() ||
          (m_valid() && (rsp_addr !== h.a || rsp_instr !== h.i || rsp_err !== h.e))) begin
        failed++;
        $display("FAIL errors_cycle %0d: got rdy=%b v=%b a=%h i=%h e=%b, expected rdy=%b v=%b a=%h i=%h e=%b",
                 cyc, req_ready, rsp_valid, rsp_addr, rsp_instr, rsp_err, exp_ready(), m_valid(), h.a, h.i, h.e);
      end
      if (rsp_valid && rsp_ready && !flush) begin got_a.push_back(rsp_addr); got_i.push_back(rsp_instr); got_e.push_back(rsp_err); end
      tick();
    end
    req_valid = 1'b0;
    tests++;
    if (got_a.size() != 2 || got_a[0] !== 32'h6 || got_a[1] !== 32'h400 || got_e[0] !== 1'b1 || got_e[1] !== 1'b1 ||
        got_i[0] !== 32'h0000_0013 || got_i[1] !== 32'h0000_0013) begin
      failed++;
      $display("FAIL errors_result: got %0d responses, expected 2 with err=1 instr=00000013", got_a.size());
    end
  endtask

  task automatic test_collision();
    exp_t h;
    logic [31:0] old;
    old = mem_m[5];
    clear_got();
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 2);
      req_addr = 32'h14;
      load_en = (c == 0);
      load_addr = 8'd5;
      load_data = 32'hDEAD_BEEF;
      #1; h = m_head(); tests++;
      if (req_ready !== exp_ready() || rsp_valid !== m_valid() ||
          (m_valid() && (rsp_addr !== h.a || rsp_instr !== h.i || rsp_err !== h.e))) begin
        failed++;
        $display("FAIL collision_cycle %0d: got rdy=%b v=%b a=%h i=%h e=%b, expected rdy=%b v=%b a=%h i=%h e=%b",
                 cyc, req_ready, rsp_valid, rsp_addr, rsp_instr, rsp_err, exp_ready(), m_valid(), h.a, h.i, h.e);
      end
      if (rsp_valid && rsp_ready && !flush) begin got_a.push_back(rsp_addr); got_i.push_back(rsp_instr); got_e.push_back(rsp_err); end
      tick();
    end
    req_valid = 1'b0;
    load_en = 1'b0;
    tests++;
    if (got_i.size() != 2 || got_i[0] !== old || got_i[1] !== 32'hDEAD_BEEF) begin
      failed++;
      $display("FAIL collision_result: got %0d responses first %h, expected %h then deadbeef",
               got_i.size(), (got_i.size() > 0) ? got_i[0] : 32'h0, old);
    end
  endtask

  task automatic test_reset_mid();
    exp_t h;
    rsp_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_valid = (c < 2);
      req_addr = 32'(c * 4);
      #1; h = m_head(); tests++;
      if (req_ready !== exp_ready() || rsp_valid !== m_valid() ||
          (m_valid() && (rsp_addr !== h.a || rsp_instr !== h.i || rsp_err !== h.e))) begin
        failed++;
        $display("FAIL reset_mid_cycle %0d: got rdy=%b v=%b a=%h i=%h e=%b, expected rdy=%b v=%b a=%h i=%h e=%b",
                 cyc, req_ready, rsp_valid, rsp_addr, rsp_instr, rsp_err, exp_ready(), m_valid(), h.a, h.i, h.e);
      end
      tick();
    end
    req_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_async: got v=%b rdy=%b, expected v=0 rdy=0 immediately", rsp_valid, req_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    clear_got();
    for (int c = 0; c < 5; c++) begin
      req_valid = (c == 0);
      req_addr = 32'h0;
      #1; h = m_head(); tests++;
      if (req_ready !== exp_ready() || rsp_valid !== m_valid() ||
          (m_valid() && (rsp_addr !== h.a || rsp_instr !== h.i || rsp_err !== h.e))) begin
        failed++;
        $display("FAIL reset_mid_after %0d: got rdy=%b v=%b a=%h i=%h e=%b, expected rdy=%b v=%b a=%h i=%h e=%b",
                 cyc, req_ready, rsp_valid, rsp_addr, rsp_instr, rsp_err, exp_ready(), m_valid(), h.a, h.i, h.e);
      end
      if (rsp_valid && rsp_ready && !flush) begin got_a.push_back(rsp_addr); got_i.push_back(rsp_instr); got_e.push_back(rsp_err); end
      tick();
    end
    req_valid = 1'b0;
    tests++;
    if (got_i.size() != 1 || got_i[0] !== 32'h1111_1111) begin
      failed++;
      $display("FAIL reset_mid_retained: got %0d responses first %h, expected one 11111111",
               got_i.size(), (got_i.size() > 0) ? got_i[0] : 32'h0);
    end
  endtask

  task automatic test_random();
    exp_t h;
    int r;
    for (int c = 0; c < 406; c++) begin
      if (c < 400) begin
        r = $urandom_range(0, 15);
        req_valid = ($urandom_range(0, 3) != 0);
        if (r == 0)      req_addr = $urandom;
        else if (r == 1) req_addr = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
        else             req_addr = 32'($urandom_range(0, 255)) << 2;
        rsp_ready = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 24) == 0);
        load_en = ($urandom_range(0, 7) == 0);
        load_addr = 8'($urandom_range(0, 255));
        load_data = $urandom;
      end else begin
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        flush = 1'b0;
        load_en = 1'b0;
      end
      #1; h = m_head(); tests++;
      if (req_ready !== exp_ready() || rsp_valid !== m_valid() ||
          (m_valid() && (rsp_addr !== h.a || rsp_instr !== h.i || rsp_err !== h.e))) begin
        failed++;
        $display("FAIL random_cycle %0d: got rdy=%b v=%b a=%h i=%h e=%b, expected rdy=%b v=%b a=%h i=%h e=%b",
                 cyc, req_ready, rsp_valid, rsp_addr, rsp_instr, rsp_err, exp_ready(), m_valid(), h.a, h.i, h.e);
      end
      tick();
    end
    tests++;
    if (rsp_valid !== 1'b0 || q.size() != 0) begin
      failed++;
      $display("FAIL random_drain: got v=%b, expected 0 with model queue %0d", rsp_valid, q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = 32'h0;
    flush = 1'b0;
    rsp_ready = 1'b0;
    load_en = 1'b0;
    load_addr = 8'h0;
    load_data = 32'h0;
    test_reset();
    test_load();
    test_stream();
    test_backpressure();
    test_flush();
    test_errors();
    test_collision();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: stalled at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
